// File: rtl/fu_issue_buffer_if.sv
// Packet type shared by the RS, the issue buffer and the FU bank, plus the
// RS-to-buffer-to-FU bundle carrying enqueue slots, per-FU avail and issued packets.
package fu_issue_pkg;
    typedef struct packed {
        logic        valid;
        logic [5:0]  opcode;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [5:0]  dest_prn;
    } fu_packet_t;

    localparam logic [1:0] CLS_ALU   = 2'd0;
    localparam logic [1:0] CLS_MULT  = 2'd1;
    localparam logic [1:0] CLS_LOAD  = 2'd2;
    localparam logic [1:0] CLS_STORE = 2'd3;
endpackage

interface fu_issue_if #(
    parameter int N            = 3,
    parameter int NUM_FU_ALU   = 3,
    parameter int NUM_FU_MULT  = 2,
    parameter int NUM_FU_LOAD  = 1,
    parameter int NUM_FU_STORE = 1
);
    import fu_issue_pkg::*;

    fu_packet_t [N-1:0]            in_packet;
    logic       [N-1:0][1:0]       in_class;
    logic                          in_ready;
    logic       [NUM_FU_ALU-1:0]   alu_avail;
    logic       [NUM_FU_MULT-1:0]  mult_avail;
    logic       [NUM_FU_LOAD-1:0]  load_avail;
    logic       [NUM_FU_STORE-1:0] store_avail;
    fu_packet_t [NUM_FU_ALU-1:0]   fu_alu_packet;
    fu_packet_t [NUM_FU_MULT-1:0]  fu_mult_packet;
    fu_packet_t [NUM_FU_LOAD-1:0]  fu_load_packet;
    fu_packet_t [NUM_FU_STORE-1:0] fu_store_packet;

    // master: the issue buffer itself; slave: the RS / FU environment around it
    modport master (
        input  in_packet, in_class, alu_avail, mult_avail, load_avail, store_avail,
        output in_ready, fu_alu_packet, fu_mult_packet, fu_load_packet, fu_store_packet
    );
    modport slave (
        output in_packet, in_class, alu_avail, mult_avail, load_avail, store_avail,
        input  in_ready, fu_alu_packet, fu_mult_packet, fu_load_packet, fu_store_packet
    );
endinterface

// File: rtl/fu_issue_buffer.sv
// Age-ordered issue buffer: compacted entry array (index 0 oldest), oldest-first
// claim of free FUs per class, tail append of up to N RS packets per cycle.
module fu_issue_buffer
    import fu_issue_pkg::*;
#(
    parameter int N            = 3,
    parameter int DEPTH        = 8,
    parameter int NUM_FU_ALU   = 3,
    parameter int NUM_FU_MULT  = 2,
    parameter int NUM_FU_LOAD  = 1,
    parameter int NUM_FU_STORE = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash,
    fu_issue_if.master                 bus,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW         = $clog2(DEPTH + 1);
    localparam int MULT_BASE  = NUM_FU_ALU;
    localparam int LOAD_BASE  = MULT_BASE + NUM_FU_MULT;
    localparam int STORE_BASE = LOAD_BASE + NUM_FU_LOAD;
    localparam int NFU        = STORE_BASE + NUM_FU_STORE;

    // FUs are numbered in one flat space: ALUs, then MULTs, LOADs, STOREs
    function automatic logic [1:0] fu_class(input int f);
        if (f < MULT_BASE) begin
            return CLS_ALU;
        end else if (f < LOAD_BASE) begin
            return CLS_MULT;
        end else if (f < STORE_BASE) begin
            return CLS_LOAD;
        end else begin
            return CLS_STORE;
        end
    endfunction

    fu_packet_t [DEPTH-1:0]      pkt_q, pkt_d;
    logic       [DEPTH-1:0][1:0] cls_q, cls_d;
    logic       [CW-1:0]         count_q, count_d;

    logic       [NFU-1:0]        avail_s;
    logic       [NFU-1:0]        claim_s;
    fu_packet_t [NFU-1:0]        fu_pkt_s;
    fu_packet_t [NFU-1:0]        fu_out_s;
    logic       [DEPTH-1:0]      issued_s;
    logic                        in_ready_s;
    logic                        found_s;
    logic                        hit_s;
    int                          wr_s;

    assign avail_s    = {bus.store_avail, bus.load_avail, bus.mult_avail, bus.alu_avail};
    assign in_ready_s = (count_q <= CW'(DEPTH - N));

    // Oldest-first claim: each live entry takes the lowest free FU of its class
    always_comb begin
        claim_s  = '0;
        issued_s = '0;
        fu_pkt_s = '0;
        found_s  = 1'b0;
        hit_s    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            found_s = 1'b0;
            for (int f = 0; f < NFU; f++) begin
                hit_s = (CW'(i) < count_q) && !found_s && avail_s[f] && !claim_s[f]
                        && (fu_class(f) == cls_q[i]);
                claim_s[f]  = claim_s[f] | hit_s;
                found_s     = found_s | hit_s;
                fu_pkt_s[f] = hit_s ? pkt_q[i] : fu_pkt_s[f];
            end
            issued_s[i] = found_s;
        end
    end

    // Squash kills every presented packet in the same cycle
    always_comb begin
        fu_out_s = fu_pkt_s;
        for (int f = 0; f < NFU; f++) begin
            fu_out_s[f].valid = claim_s[f] & ~squash;
        end
    end

    // Next state: compact survivors toward index 0, then append accepted RS slots
    always_comb begin
        pkt_d = '0;
        cls_d = '0;
        wr_s  = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && !issued_s[i] && (wr_s < DEPTH)) begin
                pkt_d[wr_s] = pkt_q[i];
                cls_d[wr_s] = cls_q[i];
                wr_s        = wr_s + 1;
            end else begin
                wr_s = wr_s;
            end
        end
        for (int s = 0; s < N; s++) begin
            if (in_ready_s && !squash && bus.in_packet[s].valid && (wr_s < DEPTH)) begin
                pkt_d[wr_s] = bus.in_packet[s];
                cls_d[wr_s] = bus.in_class[s];
                wr_s        = wr_s + 1;
            end else begin
                wr_s = wr_s;
            end
        end
        count_d = squash ? '0 : CW'(wr_s);
    end

    // Entry array and occupancy registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pkt_q   <= '0;
            cls_q   <= '0;
            count_q <= '0;
        end else begin
            pkt_q   <= pkt_d;
            cls_q   <= cls_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready        = in_ready_s;
    assign bus.fu_alu_packet   = fu_out_s[NUM_FU_ALU-1:0];
    assign bus.fu_mult_packet  = fu_out_s[MULT_BASE +: NUM_FU_MULT];
    assign bus.fu_load_packet  = fu_out_s[LOAD_BASE +: NUM_FU_LOAD];
    assign bus.fu_store_packet = fu_out_s[STORE_BASE +: NUM_FU_STORE];
    assign count               = count_q;
endmodule
